// File: rtl/coop_comm_rx.sv
// Receive framer for the co-op link: decodes AA / X[7:0] / {6'b0,X[9:8]} frames into remote_x plus link status.
// One-cycle latency from the XM byte's rx_done to remote_x/frame_strobe; accepts a byte every cycle, no backpressure.
module coop_comm_rx #(
    parameter int BYTE_TIMEOUT = 100_000,
    parameter int LINK_TIMEOUT = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [11:0] remote_x,
    output logic        remote_valid,
    output logic        frame_strobe,
    output logic        frame_err,
    output logic        link_alive
);

    localparam logic [1:0] WAIT_START = 2'd0;
    localparam logic [1:0] GET_XL     = 2'd1;
    localparam logic [1:0] GET_XM     = 2'd2;

    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [7:0]       SOF       = 8'hAA;

    logic [1:0]       state;
    logic [7:0]       xl;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] link_cnt;
    logic             good_frame;
    logic             byte_expire;

    assign good_frame  = (state == GET_XM) && rx_done && (rx_data[7:2] == 6'd0);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign byte_expire = (state != WAIT_START) && !rx_done && (byte_cnt == BYTE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WAIT_START;
            xl           <= 8'd0;
            remote_x     <= 12'd0;
            remote_valid <= 1'b0;
            frame_strobe <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            frame_err    <= 1'b0;
            if (byte_expire) begin
                frame_err <= 1'b1;
                xl        <= 8'd0;
                state     <= WAIT_START;
            end else if (rx_done) begin
                case (state)
                    WAIT_START: begin
                        if (rx_data == SOF) state <= GET_XL;
                    end
                    GET_XL: begin
                        xl    <= rx_data;
                        state <= GET_XM;
                    end
                    GET_XM: begin
                        if (rx_data[7:2] == 6'd0) begin
                            remote_x     <= {2'b00, rx_data[1:0], xl};
                            frame_strobe <= 1'b1;
                            remote_valid <= 1'b1;
                            state        <= WAIT_START;
                        end else if (rx_data == SOF) begin
                            // Bad XM that looks like a start byte: resync on it.
                            frame_err <= 1'b1;
                            state     <= GET_XL;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_START;
                        end
                    end
                    default: state <= WAIT_START;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
        end else if ((state == WAIT_START) || rx_done || byte_expire) begin
            byte_cnt <= '0;
        end else begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // Link counter saturates at its last value so link_alive stays low until a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_cnt   <= '0;
            link_alive <= 1'b0;
        end else if (good_frame) begin
            link_cnt   <= '0;
            link_alive <= 1'b1;
        end else if (link_cnt == LINK_LAST) begin
            link_alive <= 1'b0;
        end else begin
            link_cnt <= link_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_coop_comm_rx.sv
// Directed bench for coop_comm_rx; stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_coop_comm_rx;

    localparam int K_NONE   = 0;
    localparam int K_STROBE = 1;
    localparam int K_ERR    = 2;
    localparam int K_DROP   = 3;

    typedef struct {
        int         kind;
        logic [11:0] x;
        int         cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [11:0] remote_x;
    logic        remote_valid;
    logic        frame_strobe;
    logic        frame_err;
    logic        link_alive;

    int   cyc = 0;
    int   last_cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic prev_alive = 1'b0;
    ev_t  q[$];

    coop_comm_rx #(
        .BYTE_TIMEOUT(16),
        .LINK_TIMEOUT(64),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .remote_x(remote_x),
        .remote_valid(remote_valid),
        .frame_strobe(frame_strobe),
        .frame_err(frame_err),
        .link_alive(link_alive)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(input int k);
        ev_t e;
        logic ok;
        compared++;
        if (q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got kind=%0d x=%h at cyc %0d, required no event", k, remote_x, cyc);
        end else begin
            e  = q.pop_front();
            ok = (e.kind == k) && (remote_x == e.x) && (cyc == e.cyc);
            if (k == K_STROBE) ok = ok && remote_valid && link_alive;
            if (k == K_DROP)   ok = ok && remote_valid;
            if (!ok) begin
                mismatched++;
                $display("FAIL event: got kind=%0d x=%h cyc=%0d valid=%b alive=%b, required kind=%0d x=%h cyc=%0d",
                         k, remote_x, cyc, remote_valid, link_alive, e.kind, e.x, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_alive = 1'b0;
        end else begin
            if (frame_strobe) check_ev(K_STROBE);
            if (frame_err) check_ev(K_ERR);
            if (prev_alive && !link_alive) check_ev(K_DROP);
            prev_alive = link_alive;
        end
    end

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge.
    task automatic send(input logic [7:0] b, input int gap, input int kind, input logic [11:0] x);
        ev_t e;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.x    = x;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        rx_data  = b;
        rx_done  = 1'b1;
        last_cyc = cyc + 1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push_ev(input int kind, input logic [11:0] x, input int at);
        ev_t e;
        e.kind = kind;
        e.x    = x;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_remote_x"}, remote_x, 12'h000);
        chk({tag, "_remote_valid"}, {11'd0, remote_valid}, 12'h000);
        chk({tag, "_frame_strobe"}, {11'd0, frame_strobe}, 12'h000);
        chk({tag, "_frame_err"}, {11'd0, frame_err}, 12'h000);
        chk({tag, "_link_alive"}, {11'd0, link_alive}, 12'h000);
    endtask

    initial begin
        rst     = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Byte timeout with no prior good frame, then a stray byte that must be ignored.
        send(8'hAA, 0, K_NONE, 12'h000);
        send(8'h07, 0, K_NONE, 12'h000);
        push_ev(K_ERR, 12'h000, last_cyc + 16);
        repeat (20) @(negedge clk);
        send(8'h01, 3, K_NONE, 12'h000);

        // Basic frame with 10-cycle gaps.
        send(8'hAA, 10, K_NONE, 12'h000);
        send(8'h34, 10, K_NONE, 12'h000);
        send(8'h01, 10, K_STROBE, 12'h134);

        // Junk before start; XL equal to the start byte.
        send(8'h55, 2, K_NONE, 12'h000);
        send(8'h12, 2, K_NONE, 12'h000);
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'h02, 2, K_STROBE, 12'h2AA);

        // Malformed XM, then a clean frame.
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'h10, 2, K_NONE, 12'h000);
        send(8'h84, 2, K_ERR, 12'h2AA);
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'h10, 2, K_NONE, 12'h000);
        send(8'h00, 2, K_STROBE, 12'h010);

        // Start byte in the XM slot resyncs.
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'h10, 2, K_NONE, 12'h000);
        send(8'hAA, 2, K_ERR, 12'h010);
        send(8'h20, 2, K_NONE, 12'h000);
        send(8'h03, 2, K_STROBE, 12'h320);

        // Good frame then silence: link drops 64 cycles after the strobe.
        send(8'hAA, 2, K_NONE, 12'h000);
        send(8'h45, 2, K_NONE, 12'h000);
        send(8'h02, 0, K_STROBE, 12'h245);
        push_ev(K_DROP, 12'h245, last_cyc + 64);
        repeat (80) @(negedge clk);
        chk("hold_remote_x", remote_x, 12'h245);
        chk("hold_remote_valid", {11'd0, remote_valid}, 12'h001);

        // Asynchronous reset mid-frame.
        send(8'hAA, 1, K_NONE, 12'h000);
        #3 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        send(8'h34, 2, K_NONE, 12'h000);
        send(8'h01, 2, K_NONE, 12'h000);
        repeat (10) @(negedge clk);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_events: got %0d still pending, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
